// File: rtl/layer3_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// layer3_pingpong_ctrl
//
// Controller for the layer-3 ping-pong output buffer (two banks of DEPTH
// 16-bit words). Tracks which banks hold a complete frame, accepts save
// requests from layer 3 while the target bank is empty, and streams each
// full bank out to layer 4 one word per cycle. The buffer storage itself
// lives outside this block; only bank selects and addresses are driven here.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   save         producer request to write one full frame into wr_bank
//   save_ready   wr_bank is empty; save is taken only when save && save_ready
//   wr_bank      bank the next accepted save writes
//   rd_en        buffer read strobe for (rd_bank, rd_addr)
//   rd_bank      bank currently being read
//   rd_addr      word address within rd_bank
//   layer4_ready consumer can take a word next cycle (low = stall)
//   layer4_en    buffer dout valid for layer 4 (rd_en delayed one cycle)
//   layer4_addr  index of the word on dout (rd_addr delayed one cycle)
//   frame_done   one-cycle pulse when a bank is fully consumed and released
//   overflow     (only with LAYER3_CTRL_OVERFLOW_EN) sticky flag, set after
//                any cycle with save=1 and save_ready=0, cleared by rst
//
// Optional feature macro: LAYER3_CTRL_OVERFLOW_EN
//
// Handshakes:
//   Producer: a save is a transfer exactly in the cycle where save and
//   save_ready are both high; save_ready is a function of registers only and
//   never looks at save. Consumer: rd_en is issued only while layer4_ready is
//   high, and the matching word appears on layer4_en/layer4_addr one cycle
//   later, reflecting the one-cycle buffer read latency.
// -----------------------------------------------------------------------------
module layer3_pingpong_ctrl #(
    parameter int DEPTH  = 120,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save,
    output logic              save_ready,
    output logic              wr_bank,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              layer4_ready,
    output logic              layer4_en,
    output logic [ADDR_W-1:0] layer4_addr,
    output logic              frame_done
`ifdef LAYER3_CTRL_OVERFLOW_EN
    ,
    output logic              overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [1:0]        bank_full, bank_full_nxt;
    logic              wr_bank_nxt, rd_bank_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              save_acc;

    assign save_ready = ~bank_full[wr_bank];
    assign save_acc   = save & save_ready;
    assign rd_addr    = cnt;

    // Producer and reader updates share one next-state block so that a save
    // into one bank and the release of the other bank in the same cycle both
    // land in bank_full_nxt. A save and a release can never hit the same bank
    // in one cycle: that bank is still marked full during DRAIN, so
    // save_ready is low.
    always_comb begin
        state_nxt     = state;
        bank_full_nxt = bank_full;
        wr_bank_nxt   = wr_bank;
        rd_bank_nxt   = rd_bank;
        cnt_nxt       = cnt;
        rd_en         = 1'b0;
        frame_done    = 1'b0;

        if (save_acc) begin
            bank_full_nxt[wr_bank] = 1'b1;
            wr_bank_nxt            = ~wr_bank;
        end

        case (state)
            IDLE: begin
                if (bank_full[rd_bank]) begin
                    state_nxt = READ;
                    cnt_nxt   = '0;
                end
            end
            READ: begin
                rd_en = layer4_ready;
                if (layer4_ready) begin
                    // The last address is held rather than wrapped, so cnt
                    // stays within 0..DEPTH-1.
                    if (cnt == LAST_ADDR) begin
                        state_nxt = DRAIN;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The last word's layer4_en is on the bus this cycle.
                frame_done             = 1'b1;
                bank_full_nxt[rd_bank] = 1'b0;
                rd_bank_nxt            = ~rd_bank;
                state_nxt              = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bank_full   <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            cnt         <= '0;
            layer4_en   <= 1'b0;
            layer4_addr <= '0;
        end else begin
            state     <= state_nxt;
            bank_full <= bank_full_nxt;
            wr_bank   <= wr_bank_nxt;
            rd_bank   <= rd_bank_nxt;
            cnt       <= cnt_nxt;
            layer4_en <= rd_en;
            if (rd_en) begin
                layer4_addr <= rd_addr;
            end
        end
    end

`ifdef LAYER3_CTRL_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (save && !save_ready) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_layer3_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_layer3_pingpong_ctrl
//
// Directed bench for layer3_pingpong_ctrl. Stimulus pushes the expected read
// addresses, layer-4 word indices and released banks into queues whenever it
// issues a save it expects to be accepted; a negedge monitor pops and compares
// whenever the DUT strobes rd_en, layer4_en or frame_done. Cycle-exact timing
// and reset behaviour are checked against hand-computed values.
// Inputs are driven 1 time unit after posedge; the monitor samples at negedge.
// -----------------------------------------------------------------------------
module tb_layer3_pingpong_ctrl;

    localparam int DEPTH  = 120;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              save = 1'b0;
    logic              layer4_ready = 1'b1;
    logic              save_ready;
    logic              wr_bank;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              layer4_en;
    logic [ADDR_W-1:0] layer4_addr;
    logic              frame_done;
`ifdef LAYER3_CTRL_OVERFLOW_EN
    logic              overflow;
`endif

    layer3_pingpong_ctrl #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .save        (save),
        .save_ready  (save_ready),
        .wr_bank     (wr_bank),
        .rd_en       (rd_en),
        .rd_bank     (rd_bank),
        .rd_addr     (rd_addr),
        .layer4_ready(layer4_ready),
        .layer4_en   (layer4_en),
        .layer4_addr (layer4_addr),
        .frame_done  (frame_done)
`ifdef LAYER3_CTRL_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [ADDR_W-1:0] rd_q[$];
    logic [ADDR_W-1:0] l4_q[$];
    logic              done_q[$];
    int                first_rd_q[$];
    int                done_cyc_q[$];
    int                n_checks = 0;
    int                n_pass = 0;
    logic              prev_rd_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: got a strobe, expected none (cycle %0d)", name, cyc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        rd_q.delete();
        l4_q.delete();
        done_q.delete();
        first_rd_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic push_frame(input logic bank);
        for (int i = 0; i < DEPTH; i++) begin
            rd_q.push_back(ADDR_W'(i));
            l4_q.push_back(ADDR_W'(i));
        end
        done_q.push_back(bank);
    endtask

    // Holds rst for n edges, checks the reset state, then releases rst.
    task automatic do_reset(input int n);
        rst          = 1'b1;
        save         = 1'b0;
        layer4_ready = 1'b1;
        flush();
        repeat (n) tick();
        check("rst_save_ready", save_ready, 1);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_layer4_en", layer4_en, 0);
        check("rst_layer4_addr", layer4_addr, 0);
        check("rst_frame_done", frame_done, 0);
`ifdef LAYER3_CTRL_OVERFLOW_EN
        check("rst_overflow", overflow, 0);
`endif
        rst = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int budget = 600;
        while (done_cyc_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        check("frames_done", done_cyc_q.size(), n);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_rd_en = 1'b0;
        end else begin
            if (rd_en) begin
                check("rd_en_needs_ready", layer4_ready, 1);
                if (rd_q.size() == 0) unexpected("rd_en");
                else check("rd_addr", rd_addr, rd_q.pop_front());
                if (rd_addr == 0) first_rd_q.push_back(cyc);
            end
            if (layer4_en || prev_rd_en) check("layer4_en_lag", layer4_en, prev_rd_en);
            if (layer4_en) begin
                if (l4_q.size() == 0) unexpected("layer4_en");
                else check("layer4_addr", layer4_addr, l4_q.pop_front());
            end
            if (frame_done) begin
                if (done_q.size() == 0) unexpected("frame_done");
                else check("done_bank", rd_bank, done_q.pop_front());
                done_cyc_q.push_back(cyc);
            end
            prev_rd_en = rd_en;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed so far)", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;

        // Single frame, no stalls.
        do_reset(2);
        tick();
        tick();
        s = cyc;
        save = 1'b1;
        push_frame(1'b0);
        tick();
        save = 1'b0;
        check("t1_wr_bank_toggled", wr_bank, 1);
        check("t1_save_ready_other_bank", save_ready, 1);
        wait_frames(1);
        check("t1_first_rd_cycle", first_rd_q[0], s + 2);
        check("t1_frame_done_cycle", done_cyc_q[0], s + 122);
        check("t1_rd_bank_after", rd_bank, 1);
        check("t1_save_ready_after", save_ready, 1);

        // Both banks full, third save rejected.
        do_reset(1);
        tick();
        s = cyc;
        save = 1'b1;
        push_frame(1'b0);
        tick();
        check("t2_save_ready_second", save_ready, 1);
        check("t2_wr_bank_second", wr_bank, 1);
        push_frame(1'b1);
        tick();
        check("t2_save_ready_full", save_ready, 0);
`ifdef LAYER3_CTRL_OVERFLOW_EN
        check("t2_overflow_before", overflow, 0);
`endif
        tick();
        save = 1'b0;
        check("t2_wr_bank_unchanged", wr_bank, 0);
`ifdef LAYER3_CTRL_OVERFLOW_EN
        check("t2_overflow_set", overflow, 1);
`endif
        wait_frames(2);
        check("t2_first_rd_cycle", first_rd_q[0], s + 2);
        check("t2_gap_two_cycles", first_rd_q[1], done_cyc_q[0] + 2);
        check("t2_second_done_cycle", done_cyc_q[1], done_cyc_q[0] + 122);
`ifdef LAYER3_CTRL_OVERFLOW_EN
        check("t2_overflow_sticky", overflow, 1);
`endif

        // Backpressure: five stall cycles while word 15 is pending.
        do_reset(1);
        tick();
        s = cyc;
        save = 1'b1;
        push_frame(1'b0);
        tick();
        save = 1'b0;
        while (cyc < s + 17) tick();
        for (int i = 0; i < 5; i++) begin
            layer4_ready = 1'b0;
            #1;
            check("t3_stall_rd_en", rd_en, 0);
            check("t3_stall_rd_addr", rd_addr, 15);
            tick();
        end
        layer4_ready = 1'b1;
        wait_frames(1);
        check("t3_frame_done_cycle", done_cyc_q[0], s + 127);

        // Release collision: save held high through DRAIN of the target bank.
        do_reset(1);
        tick();
        s = cyc;
        save = 1'b1;
        push_frame(1'b0);
        tick();
        push_frame(1'b1);
        tick();
        while (cyc < s + 122) tick();
        check("t4_drain_frame_done", frame_done, 1);
        check("t4_drain_save_ready", save_ready, 0);
        check("t4_drain_rd_bank", rd_bank, 0);
        tick();
        check("t4_after_save_ready", save_ready, 1);
        check("t4_after_wr_bank", wr_bank, 0);
        push_frame(1'b0);
        tick();
        save = 1'b0;
        check("t4_accept_wr_bank", wr_bank, 1);
        check("t4_accept_save_ready", save_ready, 0);
        wait_frames(3);

        // Reset mid-frame at word 50, then restart.
        do_reset(1);
        tick();
        s = cyc;
        save = 1'b1;
        push_frame(1'b0);
        tick();
        save = 1'b0;
        while (cyc < s + 52) tick();
        check("t5_rd_en_word50", rd_en, 1);
        check("t5_rd_addr_word50", rd_addr, 50);
        do_reset(1);
        tick();
        s = cyc;
        save = 1'b1;
        push_frame(1'b0);
        tick();
        save = 1'b0;
        wait_frames(1);
        check("t5_restart_first_rd", first_rd_q[0], s + 2);

        tick();
        tick();
        check("end_rd_q_empty", rd_q.size(), 0);
        check("end_l4_q_empty", l4_q.size(), 0);
        check("end_done_q_empty", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer3_pingpong_ctrl.md
Name: layer3_pingpong_ctrl

Overview:
- Controller for the layer-3 ping-pong output buffer: two banks of DEPTH 16-bit words.
- Producer side: tracks bank occupancy, accepts layer-3 save pulses and applies backpressure when both banks are full.
- Consumer side: sequences the per-word read stream into layer 4, with a ready/stall handshake and one-cycle memory read latency.
- Drives bank select and read address for the buffer storage. Holds no feature data itself.

Parameters:
- DEPTH, 120, words per bank (one layer-3 output frame).
- ADDR_W, 7, width of read address; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- save  input  1  producer request: write one full frame into the bank selected by wr_bank this cycle.
- save_ready  output  1  wr_bank is empty; a save is accepted only when save && save_ready.
- wr_bank  output  1  bank the next accepted save writes.
- rd_en  output  1  buffer read strobe for (rd_bank, rd_addr).
- rd_bank  output  1  bank being read.
- rd_addr  output  ADDR_W  word address within rd_bank.
- layer4_ready  input  1  consumer can take a word next cycle; low = stall.
- layer4_en  output  1  buffer dout is valid for layer 4 (rd_en delayed by 1 cycle).
- layer4_addr  output  ADDR_W  index of the word on dout (rd_addr delayed by 1 cycle).
- frame_done  output  1  one-cycle pulse when a bank has been fully consumed and released.

Behaviour:
- Reset (synchronous): state=IDLE, bank_full=2'b00, wr_bank=0, rd_bank=0, cnt=0. All outputs 0 except save_ready=1.
- save_ready = ~bank_full[wr_bank], combinational from registers only; it never depends on save.
- Accepted save at edge T: bank_full[wr_bank]<=1 and wr_bank toggles, both visible at T+1.
- A save while save_ready=0 is ignored: no state change.
- Reader FSM states: IDLE, READ, DRAIN.
- IDLE: if bank_full[rd_bank]=1, go to READ and clear cnt to 0. Otherwise stay.
- READ: rd_en = layer4_ready (combinational); rd_addr = cnt.
  - On rd_en, cnt increments.
  - On rd_en with cnt==DEPTH-1, go to DRAIN.
  - With layer4_ready=0, rd_addr holds and nothing is issued.
- DRAIN: one cycle, waits for the last word's layer4_en.
  - Then bank_full[rd_bank]<=0, rd_bank toggles, frame_done=1 for this cycle, next state IDLE.
- layer4_en and layer4_addr are registered: the cycle after rd_en they equal 1 and the issued address. Otherwise layer4_en=0 and layer4_addr holds.
- Latency:
  - save accepted at T → bank_full set at T+1 → READ at T+2.
  - First rd_en at T+2 (if layer4_ready=1); first layer4_en at T+3.
  - Last layer4_en at T+3+DEPTH-1 with no stalls; frame_done in the same cycle.
- Per frame: exactly DEPTH rd_en pulses with addresses 0..DEPTH-1 ascending, no gaps except stalls. cnt never reaches DEPTH.
- Simultaneous release and save on the same bank: save_ready is still 0 that cycle, so the save is rejected. save_ready rises the next cycle.
- Save into the other bank during READ: accepted normally.
  - IDLE re-enters READ the cycle after DRAIN if that bank is full, so back-to-back frames have a 2-cycle bubble.
- Reset mid-frame: aborts immediately, both banks are marked empty, and no frame_done is issued.

Optional Feature:
- Macro: LAYER3_CTRL_OVERFLOW_EN.
- Defined: adds output port `overflow` (1 bit, sticky). It sets at the edge after any cycle with save=1 and save_ready=0, and clears only on rst. Reset value is 0.
- Undefined: the port is absent and rejected saves are silently dropped. All other behaviour is identical.

Test Plan:
- Single frame: rst 2 cycles, save pulse at cycle 5, layer4_ready=1 → rd_en cycles 7..126 with addr 0..119; layer4_en cycles 8..127; frame_done at 127; rd_bank=1 afterwards.
- Both banks full: saves at cycles 5 and 6, third save at 7 → save_ready=0 at 7 and the third save is ignored; bank 0 read first, then bank 1 after a 2-cycle gap; two frame_done pulses.
- Backpressure: layer4_ready low for cycles 20..24 mid-frame → rd_addr frozen, no layer4_en gaps except matching ones; still exactly 120 words with addrs 0..119 in order.
- Release collision: wr_bank==rd_bank full, save held high through the DRAIN cycle → rejected in DRAIN, accepted the next cycle, and that bank is read again.
- Reset mid-frame at word 50 → cycle after: layer4_en=0, save_ready=1, wr_bank=rd_bank=0, no frame_done; a new save restarts at addr 0.
- With LAYER3_CTRL_OVERFLOW_EN: repeat the both-banks-full test → overflow=1 from the cycle after the rejected save until rst.
